// File: rtl/boreal_cursor_pkg.sv
// boreal_cursor_pkg: shared sizes and FSM state type for the acquisition sequencer
package boreal_cursor_pkg;
    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 24;
    localparam int CH_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT,
        S_EMIT,
        S_GAP,
        S_HALTED
    } acq_state_t;
endpackage

// File: rtl/boreal_acq_watchdog.sv
// boreal_acq_watchdog: WAIT-state cycle counter that flags expiry after TIMEOUT_CYC cycles
//   clk, rst : clock, async active-high reset
//   load     : restart the count (conversion being issued)
//   run      : count this cycle (sequencer waiting on the ADC)
//   expire   : high in the TIMEOUT_CYC-th consecutive run cycle
module boreal_acq_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= '0;
        else if (run) cnt <= cnt + 1'b1;
    end

    assign expire = run && cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/boreal_acq_sequencer.sv
// boreal_acq_sequencer: round-robin ADC acquisition FSM with frame counting and packet requests
//   clk, rst              : clock, async active-high reset
//   enable                : run acquisition
//   emergency_halt_n      : 0 aborts to HALTED, dropping the partial frame
//   adc_conv_start/adc_ch : conversion request and channel to the ADC
//   adc_valid/adc_data    : ADC sample strobe and data
//   out_*                 : registered sample, channel tag and one-cycle ready strobe
//   uart_busy             : packetiser busy; holds back send_packet_strobe
//   send_packet_strobe    : one request per PKT_DIV completed frames (coalesced)
//   frame_cnt, timeout_err, busy : status
// Macro BOREAL_ACQ_TIMEOUT_EN adds the WAIT watchdog; without it WAIT waits forever.
module boreal_acq_sequencer #(
    parameter int NUM_CH      = boreal_cursor_pkg::NUM_CH,
    parameter int SAMPLE_W    = boreal_cursor_pkg::SAMPLE_W,
    parameter int TIMEOUT_CYC = 255,
    parameter int GAP_CYC     = 2,
    parameter int PKT_DIV     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                emergency_halt_n,
    output logic                adc_conv_start,
    output logic [2:0]          adc_ch,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic [2:0]          out_channel_sel,
    output logic [SAMPLE_W-1:0] out_raw_adc,
    output logic                out_data_ready,
    input  logic                uart_busy,
    output logic                send_packet_strobe,
    output logic [15:0]         frame_cnt,
    output logic                timeout_err,
    output logic                busy
);
    import boreal_cursor_pkg::*;

    localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;

    acq_state_t      state, state_nx;
    logic [CH_W-1:0] ch_idx;
    logic [GW-1:0]   gap_cnt;
    logic [15:0]     frame_nx;
    logic            pkt_pending, pkt_set, last_ch, take, expire;

`ifdef BOREAL_ACQ_TIMEOUT_EN
    boreal_acq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .load   (state == S_CONV),
        .run    (state == S_WAIT),
        .expire (expire)
    );
`else
    // no watchdog: never expires (TIMEOUT_CYC is referenced only to keep the parameter live)
    assign expire = TIMEOUT_CYC < 0;
`endif

    assign adc_ch   = ch_idx;
    assign last_ch  = ch_idx == CH_W'(NUM_CH - 1);
    assign take     = state == S_WAIT && (adc_valid || expire);
    assign frame_nx = frame_cnt + 16'd1;
    assign pkt_set  = state == S_EMIT && last_ch && int'(frame_nx) % PKT_DIV == 0;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (enable) state_nx = S_CONV;
            S_CONV:   state_nx = S_WAIT;
            S_WAIT:   if (take) state_nx = S_EMIT;
            S_EMIT:   state_nx = GAP_CYC > 0 ? S_GAP : (enable ? S_CONV : S_IDLE);
            S_GAP:    if (gap_cnt == GW'(GAP_CYC - 1)) state_nx = enable ? S_CONV : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        // halt overrides everything, including a same-cycle ADC sample
        if (!emergency_halt_n) state_nx = S_HALTED;
        adc_conv_start     = emergency_halt_n && state == S_CONV;
        out_data_ready     = emergency_halt_n && state == S_EMIT;
        send_packet_strobe = emergency_halt_n && pkt_pending && !uart_busy;
        busy               = state != S_IDLE && state != S_HALTED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            ch_idx          <= '0;
            gap_cnt         <= '0;
            pkt_pending     <= 1'b0;
            frame_cnt       <= '0;
            out_raw_adc     <= '0;
            out_channel_sel <= '0;
            timeout_err     <= 1'b0;
        end else begin
            state   <= state_nx;
            gap_cnt <= state == S_GAP ? gap_cnt + 1'b1 : '0;
            if (!emergency_halt_n) begin
                ch_idx      <= '0;
                pkt_pending <= 1'b0;
            end else begin
                if (take) begin
                    out_raw_adc     <= adc_valid ? adc_data : '0;
                    out_channel_sel <= ch_idx;
                    timeout_err     <= timeout_err | ~adc_valid;
                end
                if (state == S_EMIT) begin
                    ch_idx <= last_ch ? '0 : ch_idx + 1'b1;
                    if (last_ch) frame_cnt <= frame_nx;
                end
                // a new packet boundary wins over a same-cycle strobe clear
                pkt_pending <= pkt_set | (pkt_pending & uart_busy);
            end
        end
    end
endmodule

// File: tb/tb_boreal_acq_sequencer.sv
// tb_boreal_acq_sequencer: randomized self-checking bench with a transaction-level reference model
module tb_boreal_acq_sequencer;
    localparam int NUM_CH = 8, SAMPLE_W = 24, TIMEOUT_CYC = 255, GAP_CYC = 2, PKT_DIV = 4;

    logic                clk = 0, rst = 1, enable = 0, emergency_halt_n = 1;
    logic                adc_valid = 0, uart_busy = 0;
    logic [SAMPLE_W-1:0] adc_data = '0;
    logic                adc_conv_start, out_data_ready, send_packet_strobe, timeout_err, busy;
    logic [2:0]          adc_ch, out_channel_sel;
    logic [SAMPLE_W-1:0] out_raw_adc;
    logic [15:0]         frame_cnt;

    boreal_acq_sequencer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC(GAP_CYC), .PKT_DIV(PKT_DIV)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .emergency_halt_n(emergency_halt_n),
        .adc_conv_start(adc_conv_start), .adc_ch(adc_ch), .adc_valid(adc_valid),
        .adc_data(adc_data), .out_channel_sel(out_channel_sel), .out_raw_adc(out_raw_adc),
        .out_data_ready(out_data_ready), .uart_busy(uart_busy),
        .send_packet_strobe(send_packet_strobe), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int                  ch;
        logic [SAMPLE_W-1:0] data;
        int                  cyc;
        bit                  to;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   mch = 0, mframe = 0, n_strobe = 0, last_emit = -1;
    bit   pend = 0, mto = 0, chk_gap = 0, spurious = 0, pattern = 1;
    int   dly_min = 4, dly_max = 4, silent_ch = -1, slow_ch = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC: answers each conversion after a delay; may inject stray strobes outside WAIT
    initial begin : adc_model
        forever begin
            @(negedge clk);
            if (adc_conv_start) begin : conv
                int ch, d, c;
                ch = int'(adc_ch);
                c  = cyc;
                if (ch == silent_ch) q.push_back('{ch, '0, c + TIMEOUT_CYC + 1, 1'b1});
                else begin
                    d = ch == slow_ch ? TIMEOUT_CYC : int'($urandom_range(dly_max, dly_min));
                    repeat (d) @(posedge clk);
                    #1;
                    adc_valid = 1;
                    adc_data  = pattern ? SAMPLE_W'(ch * 24'h001000) : SAMPLE_W'($urandom);
                    q.push_back('{ch, adc_data, cyc + 1, 1'b0});
                    @(posedge clk);
                    #1 adc_valid = 0;
                end
            end else if (spurious && out_data_ready && $urandom_range(1, 0) == 1) begin
                adc_valid = 1;
                adc_data  = SAMPLE_W'($urandom);
                @(posedge clk);
                #1 adc_valid = 0;
            end
        end
    end

    // reference model: expected sample stream, channel rotation, frames and packet requests
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || !emergency_halt_n) begin
                check("quiet_ready", out_data_ready, 0);
                check("quiet_pkt", send_packet_strobe, 0);
                pend = 0;
                mch = 0;
                last_emit = -1;
                q.delete();
                if (rst) begin
                    mframe = 0;
                    mto = 0;
                end
            end
            check("frame_cnt", frame_cnt, mframe);
            if (!rst && emergency_halt_n) begin
                check("pkt_strobe", send_packet_strobe, pend && !uart_busy);
                if (send_packet_strobe) n_strobe++;
                if (pend && !uart_busy) pend = 0;
                if (adc_conv_start) begin
                    check("conv_ch", adc_ch, mch);
                    if (chk_gap && last_emit >= 0) check("gap", cyc - last_emit, GAP_CYC + 1);
                end
                if (out_data_ready) begin
                    if (q.size() == 0) check("extra_ready", out_data_ready, 0);
                    else begin
                        e = q.pop_front();
                        check("ch", out_channel_sel, e.ch);
                        check("data", out_raw_adc, e.data);
                        check("latency", cyc, e.cyc);
                        mch = (e.ch + 1) % NUM_CH;
                        if (e.to) mto = 1;
                        if (e.ch == NUM_CH - 1) begin
                            mframe = (mframe + 1) % 65536;
                            if (mframe % PKT_DIV == 0) pend = 1;
                        end
                        last_emit = cyc;
                    end
                end
            end
            check("timeout_err", timeout_err, mto);
        end
    end

    task automatic wait_frame(input int target, input int budget);
        int n = 0;
        while (mframe != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame", mframe == target, 1);
    endtask

    task automatic wait_conv(input int ch, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(adc_conv_start && (ch < 0 || int'(adc_ch) == ch)) && n < budget);
        check("wait_conv", adc_conv_start, 1);
    endtask

    task automatic halt_hold();
        repeat (10) @(posedge clk);
        #1 emergency_halt_n = 1;
    endtask

    initial begin : stim
        int s, n;
        #1;
        check("rst_busy", busy, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_conv", adc_conv_start, 0);
        check("rst_adc_ch", adc_ch, 0);
        check("rst_sel", out_channel_sel, 0);
        check("rst_raw", out_raw_adc, 0);
        check("rst_to", timeout_err, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        enable = 1;

        // one frame with the ch*0x1000 pattern, then four frames to the first packet
        wait_frame(1, 200);
        wait_frame(4, 800);
        repeat (3) @(negedge clk);
        check("pkt_once", n_strobe, 1);

        // packet held off by a long busy, released on the first idle cycle
        s = n_strobe;
        @(posedge clk);
        #1 uart_busy = 1;
        wait_frame(8, 1000);
        repeat (100) @(posedge clk);
        #1 uart_busy = 0;
        repeat (3) @(negedge clk);
        check("pkt_after_busy", n_strobe, s + 1);

        // randomized run
        pattern = 0;
        dly_min = 1;
        dly_max = 6;
        spurious = 1;
        last_emit = -1;
        chk_gap = 1;
        repeat (3000) begin
            @(posedge clk);
            #1;
            if ($urandom_range(9, 0) == 0) uart_busy = ~uart_busy;
        end
        chk_gap = 0;
        spurious = 0;
        uart_busy = 0;

        // enable drop completes the sample and keeps the channel position
        enable = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check("drain_idle", busy, 0);
        check("drain_queue", q.size(), 0);
        repeat (5) @(posedge clk);
        #1 enable = 1;
        wait_conv(-1, 20);

        // halt during the ch5 wait
        dly_min = 4;
        dly_max = 4;
        wait_conv(5, 200);
        s = n_strobe;
        @(posedge clk);
        #1 emergency_halt_n = 0;
        @(negedge clk);
        @(negedge clk);
        check("halt_busy", busy, 0);
        halt_hold();
        wait_conv(0, 20);
        check("halt_no_pkt", n_strobe, s);

        // halt in the same cycle as the ADC answer
        wait_conv(-1, 20);
        repeat (4) @(posedge clk);
        #1 emergency_halt_n = 0;
        halt_hold();
        wait_conv(0, 20);

`ifdef BOREAL_ACQ_TIMEOUT_EN
        // answer exactly on the expiry cycle: sample wins, no error
        slow_ch = 2;
        n = 0;
        while (mch != 3 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("slow_done", mch, 3);
        slow_ch = -1;
        // silent channel: zero sample, sticky error, next channel converts
        silent_ch = 3;
        n = 0;
        while (!mto && n < 1200) begin
            @(negedge clk);
            n++;
        end
        silent_ch = -1;
        check("to_flag", timeout_err, 1);
        wait_conv(4, 20);
`endif

        // reset in the middle of a wait: outputs clear without a clock edge
        wait_conv(-1, 40);
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_conv", adc_conv_start, 0);
        check("arst_ready", out_data_ready, 0);
        check("arst_pkt", send_packet_strobe, 0);
        check("arst_to", timeout_err, 0);
        check("arst_frame", frame_cnt, 0);
        check("arst_raw", out_raw_adc, 0);
        check("arst_sel", out_channel_sel, 0);
        check("arst_adc_ch", adc_ch, 0);
        enable = 0;
        repeat (8) @(posedge clk);
        #1 rst = 0;
        #2;
        dut.frame_cnt = 16'hFFFF;
        mframe = 65535;
        s = n_strobe;
        @(posedge clk);
        #1 enable = 1;
        wait_frame(0, 200);
        repeat (3) @(negedge clk);
        check("wrap_pkt", n_strobe, s + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : guard
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
